// File: rtl/img_video_pkg.sv
// rtl/img_video_pkg.sv - pixel format encodings shared by the image unpack path
package img_video_pkg;

   localparam logic [1:0] MODE_332 = 2'd0;
   localparam logic [1:0] MODE_565 = 2'd1;
   localparam logic [1:0] MODE_888 = 2'd2;

   // Reserved mode 3 behaves as 888, so anything not 332/565 is one pixel per word.
   function automatic logic [2:0] ppw_of(input logic [1:0] mode);
      case (mode)
         MODE_332: ppw_of = 3'd4;
         MODE_565: ppw_of = 3'd2;
         default:  ppw_of = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/pix_expand.sv
// rtl/pix_expand.sv - expands a packed 8/16/24-bit pixel to RGB888 by bit replication
module pix_expand
   import img_video_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic [23:0] pix,
   output logic [7:0]  red,
   output logic [7:0]  grn,
   output logic [7:0]  blu
);

   always_comb begin
      red = pix[23:16];
      grn = pix[15:8];
      blu = pix[7:0];
      case (mode)
         MODE_332: begin
            red = {pix[7:5], pix[7:5], pix[7:6]};
            grn = {pix[4:2], pix[4:2], pix[4:3]};
            blu = {4{pix[1:0]}};
         end
         MODE_565: begin
            red = {pix[15:11], pix[15:13]};
            grn = {pix[10:5], pix[10:9]};
            blu = {pix[4:0], pix[4:2]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/img_pixel_unpack.sv
// rtl/img_pixel_unpack.sv - VGA raster timing plus FIFO word to RGB pixel unpacking
module img_pixel_unpack
   import img_video_pkg::*;
#(
   parameter int LW   = 11,
   parameter int BUSW = 32
) (
   input  logic            i_pixclk,
   input  logic            i_reset,
   input  logic            i_en,
   input  logic [1:0]      i_mode,
   input  logic [LW-1:0]   i_hm_width,
   input  logic [LW-1:0]   i_hm_porch,
   input  logic [LW-1:0]   i_hm_synch,
   input  logic [LW-1:0]   i_hm_raw,
   input  logic [LW-1:0]   i_vm_width,
   input  logic [LW-1:0]   i_vm_porch,
   input  logic [LW-1:0]   i_vm_synch,
   input  logic [LW-1:0]   i_vm_raw,
   output logic            o_rd,
   input  logic            i_valid,
   input  logic [BUSW-1:0] i_word,
   output logic            o_newframe,
   output logic            o_hsync,
   output logic            o_vsync,
   output logic [7:0]      o_red,
   output logic [7:0]      o_grn,
   output logic [7:0]      o_blu,
   output logic            o_underflow
);

   logic [LW-1:0]   hpos, vpos;
   logic [1:0]      sub, sub_inc;
   logic [BUSW-1:0] wreg, word;
   logic            frame_err;
   logic [2:0]      ppw;
   logic            h_last, active, need, nf_cond, uf_cond, show_px;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [23:0]     pix;
   logic [7:0]      exp_red, exp_grn, exp_blu;

   always_comb begin
      ppw      = ppw_of(i_mode);
      h_last   = (hpos == i_hm_raw - LW'(1));
      active   = i_en && (hpos < i_hm_width) && (vpos < i_vm_width);
      need     = active && (sub == 2'd0);
      o_rd     = need && i_valid && !frame_err && !i_reset;
      uf_cond  = need && !i_valid && !frame_err;
      nf_cond  = h_last && (vpos == i_vm_width - LW'(1));
      sub_inc  = (({1'b0, sub} + 3'd1) == ppw) ? 2'd0 : sub + 2'd1;
      show_px  = active && !frame_err && ((sub != 2'd0) || i_valid);
      // Pixel 0 comes straight off the FIFO head in the cycle it is popped.
      word     = (sub == 2'd0) ? i_word : wreg;
      case (sub)
         2'd0:    byte_sel = word[31:24];
         2'd1:    byte_sel = word[23:16];
         2'd2:    byte_sel = word[15:8];
         default: byte_sel = word[7:0];
      endcase
      half_sel = sub[0] ? word[15:0] : word[31:16];
      case (i_mode)
         MODE_332: pix = {16'd0, byte_sel};
         MODE_565: pix = {8'd0, half_sel};
         default:  pix = word[23:0];
      endcase
   end

   pix_expand u_expand (
      .mode (i_mode),
      .pix  (pix),
      .red  (exp_red),
      .grn  (exp_grn),
      .blu  (exp_blu)
   );

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         hpos        <= '0;
         vpos        <= '0;
         sub         <= 2'd0;
         wreg        <= '0;
         frame_err   <= 1'b0;
         o_hsync     <= 1'b1;
         o_vsync     <= 1'b1;
         o_red       <= 8'd0;
         o_grn       <= 8'd0;
         o_blu       <= 8'd0;
         o_underflow <= 1'b0;
         o_newframe  <= 1'b1;
      end else if (!i_en) begin
         hpos        <= '0;
         vpos        <= '0;
         sub         <= 2'd0;
         frame_err   <= 1'b0;
         o_hsync     <= 1'b1;
         o_vsync     <= 1'b1;
         o_red       <= 8'd0;
         o_grn       <= 8'd0;
         o_blu       <= 8'd0;
         o_underflow <= 1'b0;
         o_newframe  <= 1'b1;
      end else begin
         if (h_last) begin
            hpos <= '0;
            vpos <= (vpos == i_vm_raw - LW'(1)) ? '0 : vpos + LW'(1);
            sub  <= 2'd0;
         end else begin
            hpos <= hpos + LW'(1);
            if (active)
               sub <= sub_inc;
         end
         if (o_rd)
            wreg <= i_word;
         // An underflow blanks the rest of the frame until the refill point.
         frame_err   <= nf_cond ? 1'b0 : (frame_err | uf_cond);
         o_underflow <= uf_cond;
         o_newframe  <= nf_cond;
         o_hsync     <= !((hpos >= i_hm_porch) && (hpos < i_hm_synch));
         o_vsync     <= !((vpos >= i_vm_porch) && (vpos < i_vm_synch));
         o_red       <= show_px ? exp_red : 8'd0;
         o_grn       <= show_px ? exp_grn : 8'd0;
         o_blu       <= show_px ? exp_blu : 8'd0;
      end
   end

endmodule

// File: tb/tb_img_pixel_unpack.sv
// tb/tb_img_pixel_unpack.sv - self-checking bench for img_pixel_unpack
module tb_img_pixel_unpack;

   logic        clk = 1'b0;
   logic        rst, en, rd, valid, nf, hsn, vsn, uf;
   logic [1:0]  mode;
   logic [10:0] hw, hp, hs, hr, vw, vp, vs, vr;
   logic [31:0] word;
   logic [7:0]  r, g, b;

   always #5 clk = ~clk;

   img_pixel_unpack dut (
      .i_pixclk    (clk),
      .i_reset     (rst),
      .i_en        (en),
      .i_mode      (mode),
      .i_hm_width  (hw),
      .i_hm_porch  (hp),
      .i_hm_synch  (hs),
      .i_hm_raw    (hr),
      .i_vm_width  (vw),
      .i_vm_porch  (vp),
      .i_vm_synch  (vs),
      .i_vm_raw    (vr),
      .o_rd        (rd),
      .i_valid     (valid),
      .i_word      (word),
      .o_newframe  (nf),
      .o_hsync     (hsn),
      .o_vsync     (vsn),
      .o_red       (r),
      .o_grn       (g),
      .o_blu       (b),
      .o_underflow (uf)
   );

   typedef struct {
      logic [1:0]       md;
      logic [31:0]      w;
      logic [3:0][23:0] px;
   } tv_t;

   int          checks = 0;
   int          failures = 0;
   int          c, gcyc, drop_at, fill_mode, alt_i;
   int          n_pop, n_nf, n_hs, n_vs, n_uf;
   bit          m_err, en_next, rnd_drop;
   logic [31:0] cur, fill_word;
   logic [31:0] alt [2];
   logic [31:0] q [$];
   logic        e_hs, e_vs, e_nf, e_uf, last_rd;
   logic [23:0] e_rgb, last_rgb;
   tv_t         tv [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int m_ppw(input logic [1:0] md);
      return (md == 2'd0) ? 4 : (md == 2'd1) ? 2 : 1;
   endfunction

   // Reference expansion: shift/mask the k-th pixel out and replicate high bits arithmetically.
   function automatic logic [23:0] m_pix(input logic [1:0] md, input logic [31:0] w, input int k);
      int p, a, bb, cc;
      logic [23:0] res;
      if (md == 2'd0) begin
         p  = int'((w >> (24 - 8 * k)) & 32'hFF);
         a  = p >> 5; bb = (p >> 2) & 7; cc = p & 3;
         res = {8'((a << 5) | (a << 2) | (a >> 1)), 8'((bb << 5) | (bb << 2) | (bb >> 1)), 8'(cc * 85)};
      end else if (md == 2'd1) begin
         p  = int'((w >> (16 - 16 * k)) & 32'hFFFF);
         a  = p >> 11; bb = (p >> 5) & 63; cc = p & 31;
         res = {8'((a << 3) | (a >> 2)), 8'((bb << 2) | (bb >> 4)), 8'((cc << 3) | (cc >> 2))};
      end else begin
         res = w[23:0];
      end
      return res;
   endfunction

   function automatic tv_t mk(input logic [1:0] md, input logic [31:0] w,
                              input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
      tv_t t;
      t.md = md; t.w = w; t.px = {p3, p2, p1, p0};
      return t;
   endfunction

   task automatic refill();
      while (fill_mode != 0 && q.size() < 4) begin
         if (fill_mode == 1) q.push_back(fill_word);
         else if (fill_mode == 2) q.push_back($urandom);
         else begin
            q.push_back(alt[alt_i]);
            alt_i ^= 1;
         end
      end
   endtask

   task automatic set_reset_expect();
      e_hs = 1'b1; e_vs = 1'b1; e_nf = 1'b1; e_uf = 1'b0; e_rgb = 24'd0;
      c = 0; m_err = 1'b0;
   endtask

   task automatic step_body();
      logic exp_rd;
      int   hpos, vpos, k;
      bit   act;
      gcyc++;
      en = en_next;
      refill();
      valid = (q.size() > 0) && (gcyc != drop_at) && !(rnd_drop && $urandom_range(0, 39) == 0);
      word  = (q.size() > 0) ? q[0] : 32'hDEADBEEF;
      #1;
      check("sync_nf_uf", 32'({hsn, vsn, nf, uf}), 32'({e_hs, e_vs, e_nf, e_uf}));
      check("rgb", 32'({r, g, b}), 32'(e_rgb));
      last_rgb = {r, g, b};
      n_nf += int'(nf); n_hs += int'(!hsn); n_vs += int'(!vsn); n_uf += int'(uf);
      exp_rd = 1'b0;
      if (!en) begin
         set_reset_expect();
      end else begin
         hpos = c % hr;
         vpos = c / hr;
         act  = (hpos < hw) && (vpos < vw);
         k    = hpos % m_ppw(mode);
         e_uf = 1'b0; e_rgb = 24'd0;
         if (act && k == 0 && !m_err) begin
            if (valid) begin
               exp_rd = 1'b1;
               cur = word;
            end else begin
               e_uf = 1'b1;
               m_err = 1'b1;
            end
         end
         if (act && !m_err) e_rgb = m_pix(mode, cur, k);
         e_hs = !(hpos >= hp && hpos < hs);
         e_vs = !(vpos >= vp && vpos < vs);
         e_nf = (hpos == hr - 1) && (vpos == vw - 1);
         if (e_nf) m_err = 1'b0;
         c = (c + 1) % (hr * vr);
      end
      check("o_rd", 32'(rd), 32'(exp_rd));
      last_rd = rd;
      n_pop += int'(rd);
      if (exp_rd && q.size() > 0) void'(q.pop_front());
   endtask

   task automatic step();
      @(negedge clk);
      step_body();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clr();
      n_pop = 0; n_nf = 0; n_hs = 0; n_vs = 0; n_uf = 0;
   endtask

   task automatic cfg(input logic [1:0] md, input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3);
      mode = md;
      hw = 11'(a0); hp = 11'(a1); hs = 11'(a2); hr = 11'(a3);
      vw = 11'(b0); vp = 11'(b1); vs = 11'(b2); vr = 11'(b3);
   endtask

   task automatic stop_raster();
      en_next = 1'b0;
      run(2);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; en_next = 1'b0; valid = 1'b0; word = 32'd0;
      fill_mode = 2; fill_word = 32'd0; alt_i = 0; drop_at = -1; rnd_drop = 1'b0; gcyc = 0;
      cur = 32'd0; alt[0] = 32'hF800_07E0; alt[1] = 32'h001F_FFFF;
      cfg(2'd2, 8, 10, 12, 14, 4, 5, 6, 7);
      clr();

      tv[0] = mk(2'd0, 32'hE01C_0300, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000);
      tv[1] = mk(2'd0, 32'h6D92_00FF, 24'h6D6D55, 24'h9292AA, 24'h000000, 24'hFFFFFF);
      tv[2] = mk(2'd1, 32'hF800_07E0, 24'hFF0000, 24'h00FF00, 24'hFF0000, 24'h00FF00);
      tv[3] = mk(2'd1, 32'h8410_0000, 24'h848284, 24'h000000, 24'h848284, 24'h000000);
      tv[4] = mk(2'd2, 32'h0012_3456, 24'h123456, 24'h123456, 24'h123456, 24'h123456);
      tv[5] = mk(2'd3, 32'hAB65_4321, 24'h654321, 24'h654321, 24'h654321, 24'h654321);

      repeat (2) @(negedge clk);
      #1;
      check("rst_syncs", 32'({hsn, vsn}), 32'd3);
      check("rst_nf_uf", 32'({nf, uf}), 32'd2);
      check("rst_rgb", 32'({r, g, b}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_reset_expect();
      step_body();
      run(3);

      // Reference raster: mode 2, FIFO always valid, two frames
      clr();
      en_next = 1'b1;
      run(196);
      check("a_pops", n_pop, 64);
      check("a_newframe", n_nf, 3);
      check("a_hsync_low", n_hs, 28);
      check("a_vsync_low", n_vs, 28);
      check("a_underflow", n_uf, 0);
      stop_raster();

      check("en_low_nf", 32'(nf), 32'd1);
      check("en_low_rd", 32'(rd), 32'd0);
      check("en_low_syncs", 32'({hsn, vsn}), 32'd3);
      en_next = 1'b1;
      step();
      check("en_first_pop", 32'(last_rd), 32'd1);
      run(10);
      stop_raster();

      foreach (tv[i]) begin
         cfg(tv[i].md, 4, 5, 6, 7, 1, 2, 3, 4);
         q.delete();
         fill_mode = 1;
         fill_word = tv[i].w;
         en_next = 1'b1;
         step();
         for (int j = 0; j < 4; j++) begin
            step();
            check("tbl_rgb", 32'(last_rgb), 32'(tv[i].px[j]));
         end
         run(24);
         stop_raster();
      end

      // 565 with 3-pixel lines: trailing half word is dropped each line
      cfg(2'd1, 3, 4, 5, 6, 2, 3, 4, 5);
      q.delete();
      fill_mode = 3;
      alt_i = 0;
      clr();
      en_next = 1'b1;
      run(30);
      check("m1_pops", n_pop, 4);
      stop_raster();

      // Underflow at pixel 2 of line 1, then a clean frame
      cfg(2'd2, 8, 10, 12, 14, 4, 5, 6, 7);
      q.delete();
      fill_mode = 2;
      clr();
      drop_at = gcyc + 1 + 16;
      en_next = 1'b1;
      run(196);
      check("uf_pulses", n_uf, 1);
      check("uf_pops", n_pop, 42);
      drop_at = -1;
      stop_raster();

      // Asynchronous reset mid-line
      cfg(2'd0, 8, 10, 12, 14, 4, 5, 6, 7);
      q.delete();
      en_next = 1'b1;
      run(20);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_syncs", 32'({hsn, vsn}), 32'd3);
      check("arst_nf_uf", 32'({nf, uf}), 32'd2);
      check("arst_rgb", 32'({r, g, b}), 32'd0);
      check("arst_rd", 32'(rd), 32'd0);
      @(negedge clk);
      check("arst_rd_hold", 32'(rd), 32'd0);
      rst = 1'b0;
      set_reset_expect();
      step_body();
      check("arst_first_pop", 32'(last_rd), 32'd1);
      run(100);
      stop_raster();

      // Randomized timing, modes, words and FIFO starvation
      for (int it = 0; it < 6; it++) begin
         int a0, a1, a2, a3, b0, b1, b2, b3;
         a0 = $urandom_range(0, 6); a1 = a0 + $urandom_range(0, 2);
         a2 = a1 + $urandom_range(0, 2); a3 = a2 + $urandom_range(1, 3);
         if (a3 < 2) a3 = 2;
         b0 = $urandom_range(0, 3); b1 = b0 + $urandom_range(0, 1);
         b2 = b1 + $urandom_range(0, 1); b3 = b2 + $urandom_range(1, 2);
         if (b3 < 2) b3 = 2;
         cfg(2'($urandom_range(0, 3)), a0, a1, a2, a3, b0, b1, b2, b3);
         q.delete();
         fill_mode = 2;
         rnd_drop = 1'b1;
         en_next = 1'b1;
         run(2 * a3 * b3 + 3);
         rnd_drop = 1'b0;
         stop_raster();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
